// File: rtl/alu_pkg.sv
// Shared constants for the ALU and its issue-side sequencer: widths, opcodes,
// instruction field positions and sequencer state encoding.
package alu_pkg;

    localparam int DATA_W   = 4;
    localparam int RF_DEPTH = 4;
    localparam int RA_W     = $clog2(RF_DEPTH);
    localparam int INSTR_W  = 13;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_NOT1 = 3'b101;
    localparam logic [2:0] OP_NOT2 = 3'b110;
    localparam logic [2:0] OP_LDI  = 3'b111;

    // Instruction word: [12:10] opcode, [9:8] rd, [7:6] rs1, [5:4] rs2, [3:0] imm
    localparam int OPC_LSB = 10;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 4;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WB
    } state_t;

    function automatic logic [2:0] instr_opcode(input logic [INSTR_W-1:0] word);
        return word[OPC_LSB +: 3];
    endfunction

    function automatic logic [RA_W-1:0] instr_reg(input logic [INSTR_W-1:0] word, input int lsb);
        return word[lsb +: RA_W];
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two asynchronous read ports, one synchronous write
// port, synchronous clear of every entry on reset.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   rd_addr_a,
    input  logic [RA_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [RA_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [RF_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reads see the pre-write value, so rd may alias rs1/rs2.
    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Issue-side controller for the external 4-bit ALU: accepts one instruction,
// executes it for one cycle, writes the result back and holds it for hand-off.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [2:0]         alu_opcode,
    output logic [DATA_W-1:0]  alu_op1,
    output logic [DATA_W-1:0]  alu_op2,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DATA_W-1:0]  res_data,
    output logic [RA_W-1:0]    res_rd
);

    state_t             state;
    state_t             next_state;
    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  rf_a;
    logic [DATA_W-1:0]  rf_b;
    logic [DATA_W-1:0]  wb_value;
    logic               wb_en;

    wire [2:0]      opcode = instr_opcode(instr_q);
    wire [RA_W-1:0] rd     = instr_reg(instr_q, RD_LSB);
    wire [RA_W-1:0] rs1    = instr_reg(instr_q, RS1_LSB);
    wire [RA_W-1:0] rs2    = instr_reg(instr_q, RS2_LSB);

    alu_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rs1),
        .rd_addr_b (rs2),
        .rd_data_a (rf_a),
        .rd_data_b (rf_b),
        .wr_en     (wb_en),
        .wr_addr   (rd),
        .wr_data   (wb_value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            instr_q  <= '0;
            res_data <= '0;
            res_rd   <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && instr_valid) begin
                instr_q <= instr;
            end
            if (state == ST_EXEC) begin
                res_data <= wb_value;
                res_rd   <= rd;
            end
        end
    end

    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        alu_opcode  = OP_NOP;
        alu_op1     = '0;
        alu_op2     = '0;
        wb_en       = 1'b0;
        wb_value    = '0;

        case (opcode)
            OP_NOP:  wb_value = '0;
            OP_LDI:  wb_value = instr_q[IMM_LSB +: DATA_W];
            default: wb_value = alu_result;
        endcase

        case (state)
            ST_IDLE: begin
                instr_ready = !rst;
                if (instr_valid) begin
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_opcode = opcode;
                alu_op1    = rf_a;
                alu_op2    = rf_b;
                wb_en      = (opcode != OP_NOP);
                next_state = ST_WB;
            end
            ST_WB: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a behavioural ALU beside it; table-driven
// instruction vectors plus hand-written stall and reset sequences.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [2:0]         alu_opcode;
    logic [DATA_W-1:0]  alu_op1;
    logic [DATA_W-1:0]  alu_op2;
    logic [DATA_W-1:0]  alu_result;
    logic               res_valid;
    logic               res_ready;
    logic [DATA_W-1:0]  res_data;
    logic [RA_W-1:0]    res_rd;

    typedef struct {
        logic [2:0]        op;
        logic [RA_W-1:0]   rd;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [RA_W-1:0]   rd;
    } exp_t;

    vec_t              vecs[$];
    exp_t              scoreboard[$];
    logic [DATA_W-1:0] shadow_rf [RF_DEPTH];
    int                n_checks = 0;
    int                n_fail   = 0;

    alu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_opcode  (alu_opcode),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_result  (alu_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_rd      (res_rd)
    );

    always #5 clk = ~clk;

    // Behavioural combinational ALU standing in for the real one.
    always_comb begin
        alu_result = '0;
        case (alu_opcode)
            OP_ADD:  alu_result = alu_op1 + alu_op2;
            OP_SUB:  alu_result = alu_op1 - alu_op2;
            OP_AND:  alu_result = alu_op1 & alu_op2;
            OP_OR:   alu_result = alu_op1 | alu_op2;
            OP_NOT1: alu_result = ~alu_op1;
            OP_NOT2: alu_result = ~alu_op2;
            default: alu_result = '0;
        endcase
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input int rd, input int rs1,
                                input int rs2, input logic [3:0] imm, input logic [3:0] exp_data);
        vec_t v;
        v.op = op;
        v.rd = RA_W'(rd);
        v.rs1 = RA_W'(rs1);
        v.rs2 = RA_W'(rs2);
        v.imm = imm;
        v.exp_data = exp_data;
        return v;
    endfunction

    // Waits for instr_ready, hands one instruction over and checks the EXEC cycle.
    task automatic apply_stimulus(input vec_t v, output bit ok);
        int   cyc = 0;
        exp_t e;
        while (!instr_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        ok = instr_ready;
        if (!ok) begin
            check("instr_ready_timeout", {31'b0, instr_ready}, 32'd1);
            return;
        end
        instr       = {v.op, v.rd, v.rs1, v.rs2, v.imm};
        instr_valid = 1'b1;
        e.data = v.exp_data;
        e.rd   = v.rd;
        scoreboard.push_back(e);
        @(negedge clk);
        instr_valid = 1'b0;
        check("exec_opcode", {29'b0, alu_opcode}, {29'b0, v.op});
        check("exec_op1", {28'b0, alu_op1}, {28'b0, shadow_rf[v.rs1]});
        check("exec_op2", {28'b0, alu_op2}, {28'b0, shadow_rf[v.rs2]});
        check("exec_instr_ready", {31'b0, instr_ready}, 32'd0);
    endtask

    // Waits for the result, compares it against the scoreboard, optionally stalls, then consumes it.
    task automatic check_output(input vec_t v, input int hold);
        int   lat = 1;
        exp_t e;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("res_latency", lat, 2);
        if (!res_valid || scoreboard.size() == 0) return;
        e = scoreboard.pop_front();
        check("res_data", {28'b0, res_data}, {28'b0, e.data});
        check("res_rd", {30'b0, res_rd}, {30'b0, e.rd});
        if (v.op != OP_NOP) shadow_rf[v.rd] = v.exp_data;
        for (int i = 0; i < hold; i++) begin
            instr       = {OP_LDI, v.rd, 2'd0, 2'd0, ~v.exp_data};
            instr_valid = (i % 2 == 0);
            @(negedge clk);
            check("stall_valid", {31'b0, res_valid}, 32'd1);
            check("stall_data", {28'b0, res_data}, {28'b0, e.data});
            check("stall_instr_ready", {31'b0, instr_ready}, 32'd0);
        end
        instr_valid = 1'b0;
        res_ready   = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_released", {31'b0, res_valid}, 32'd0);
        check("idle_instr_ready", {31'b0, instr_ready}, 32'd1);
    endtask

    task automatic run(input vec_t v, input int hold);
        bit ok;
        apply_stimulus(v, ok);
        if (ok) check_output(v, hold);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_res_valid"}, {31'b0, res_valid}, 32'd0);
        check({tag, "_instr_ready"}, {31'b0, instr_ready}, 32'd0);
        check({tag, "_alu_opcode"}, {29'b0, alu_opcode}, 32'd0);
        check({tag, "_alu_op1"}, {28'b0, alu_op1}, 32'd0);
        check({tag, "_alu_op2"}, {28'b0, alu_op2}, 32'd0);
        check({tag, "_res_data"}, {28'b0, res_data}, 32'd0);
        check({tag, "_res_rd"}, {30'b0, res_rd}, 32'd0);
        rst = 1'b0;
        scoreboard.delete();
        for (int i = 0; i < RF_DEPTH; i++) shadow_rf[i] = '0;
        @(negedge clk);
    endtask

    initial begin
        bit ok;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        res_ready   = 1'b0;
        for (int i = 0; i < RF_DEPTH; i++) shadow_rf[i] = '0;

        vecs.push_back(mk(OP_LDI,  1, 0, 0, 4'h5, 4'h5));
        vecs.push_back(mk(OP_LDI,  2, 0, 0, 4'h3, 4'h3));
        vecs.push_back(mk(OP_ADD,  0, 1, 2, 4'h0, 4'h8));
        vecs.push_back(mk(OP_LDI,  1, 0, 0, 4'hF, 4'hF));
        vecs.push_back(mk(OP_LDI,  2, 0, 0, 4'h1, 4'h1));
        vecs.push_back(mk(OP_ADD,  3, 1, 2, 4'h0, 4'h0));
        vecs.push_back(mk(OP_SUB,  3, 2, 1, 4'h0, 4'h2));
        vecs.push_back(mk(OP_LDI,  1, 0, 0, 4'hC, 4'hC));
        vecs.push_back(mk(OP_LDI,  2, 0, 0, 4'hA, 4'hA));
        vecs.push_back(mk(OP_AND,  0, 1, 2, 4'h0, 4'h8));
        vecs.push_back(mk(OP_OR,   0, 1, 2, 4'h0, 4'hE));
        vecs.push_back(mk(OP_NOT1, 0, 1, 2, 4'h0, 4'h3));
        vecs.push_back(mk(OP_NOT2, 0, 1, 2, 4'h0, 4'h5));
        vecs.push_back(mk(OP_NOP,  3, 1, 2, 4'h7, 4'h0));
        vecs.push_back(mk(OP_OR,   1, 3, 3, 4'h0, 4'h2));
        vecs.push_back(mk(OP_LDI,  0, 0, 0, 4'h0, 4'h0));
        vecs.push_back(mk(OP_LDI,  3, 0, 0, 4'h1, 4'h1));
        vecs.push_back(mk(OP_SUB,  2, 0, 3, 4'h0, 4'hF));
        vecs.push_back(mk(OP_LDI,  1, 0, 0, 4'h6, 4'h6));
        vecs.push_back(mk(OP_ADD,  1, 1, 1, 4'h0, 4'hC));
        vecs.push_back(mk(OP_OR,   2, 1, 1, 4'h0, 4'hC));

        @(negedge clk);
        do_reset("reset");

        for (int i = 0; i < vecs.size(); i++) run(vecs[i], 0);

        // Stalled result: data held, ready low, stray instr_valid pulses dropped.
        run(mk(OP_LDI, 0, 0, 0, 4'h9, 4'h9), 5);
        run(mk(OP_OR,  1, 0, 0, 4'h0, 4'h9), 0);

        apply_stimulus(mk(OP_LDI, 2, 0, 0, 4'hD, 4'hD), ok);
        do_reset("rst_exec");
        run(mk(OP_OR, 0, 1, 2, 4'h0, 4'h0), 0);
        run(mk(OP_OR, 0, 3, 3, 4'h0, 4'h0), 0);

        run(mk(OP_LDI, 3, 0, 0, 4'h7, 4'h7), 0);
        apply_stimulus(mk(OP_LDI, 1, 0, 0, 4'hB, 4'hB), ok);
        @(negedge clk);
        check("wb_before_reset", {31'b0, res_valid}, 32'd1);
        do_reset("rst_wb");
        run(mk(OP_OR, 2, 1, 3, 4'h0, 4'h0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue-side controller for the 4-bit ALU: accepts encoded instruction words over a valid/ready handshake, reads operands from a small internal register file, drives the ALU's operand/opcode inputs, captures the ALU result, writes it back, and presents it on a valid/ready result port. Sits between the instruction source (test harness or future fetch unit) and the combinational ALU, which is instantiated beside it at the top level.

## Interface
- DATA_W, 4: operand/result width; must match ALU operand width.
- RF_DEPTH, 4: register-file entries; index width RA_W = clog2(RF_DEPTH) = 2.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr_valid  in  1  instruction word present.
- instr_ready  out  1  sequencer can accept; high only in IDLE with rst low.
- instr  in  13  [12:10] opcode, [9:8] rd, [7:6] rs1, [5:4] rs2, [3:0] imm.
- alu_opcode  out  3  to ALU opcode.
- alu_op1  out  DATA_W  to ALU operand 1.
- alu_op2  out  DATA_W  to ALU operand 2.
- alu_result  in  DATA_W  from ALU output (combinational path).
- res_valid  out  1  result available.
- res_ready  in  1  result consumer accepts.
- res_data  out  DATA_W  result value.
- res_rd  out  RA_W  destination index of the result.

## Operation
- Opcodes: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 NOT op1, 110 NOT op2, 111 LDI.
- States: IDLE, EXEC, WB.
- IDLE: instr_ready=1; on instr_valid&&instr_ready latch instr, go EXEC.
- EXEC (one cycle): alu_opcode=latched opcode, alu_op1=RF[rs1], alu_op2=RF[rs2]; at end of cycle capture result: alu_result for 001-110, imm for LDI, 0 for NOP; write RF[rd] except for NOP; go WB.
- WB: res_valid=1, res_data/res_rd stable; on res_ready go IDLE.
- Outside EXEC alu_opcode=000, alu_op1=alu_op2=0.
- Arithmetic mod 2^DATA_W: carry/borrow dropped (ALU behaviour); 4'hF+4'h1=0, 4'h0-4'h1=4'hF.
- rs1/rs2 == rd allowed: read uses pre-write value.

## Timing
- Reset: state IDLE, all RF entries 0, latched instr 0, res_valid=0, res_data=0, res_rd=0, ALU outputs 0, instr_ready=0 while rst high.
- Accept at edge N; EXEC during cycle N+1; RF updated and res_valid high from cycle N+2.
- Minimum 3 cycles per instruction; no overlap: instr_ready low in EXEC and WB.
- res_valid held with stable data until res_ready; res_ready high in first WB cycle returns to IDLE at that edge, next accept possible one cycle later.
- res_ready ignored outside WB; instr_valid ignored outside IDLE (no buffering).
- Writeback precedes result handshake: a stalled result does not delay RF visibility.
- rst in any state overrides everything at that edge: pending instruction and result dropped, RF cleared.

## Structure
- Shared package alu_pkg: opcode localparams (OP_NOP..OP_LDI), instruction field positions, state encoding; ALU adopts the same opcode constants.
- Sub-module alu_regfile: RF_DEPTH x DATA_W, two asynchronous read ports, one synchronous write port, synchronous reset to 0.
- ALU not instantiated inside; top-level wires alu_opcode/op1/op2/result.

## Test plan
- Reset then LDI r1=4'h5, LDI r2=4'h3, ADD r0=r1+r2 -> res_data 4'h8, res_rd 0, valid 2 cycles after each accept.
- LDI r1=4'hF, LDI r2=4'h1, ADD r3=r1+r2 -> 4'h0; SUB r3=r2-r1 -> 4'h2 (wrap).
- AND/OR/NOT1/NOT2 with r1=4'hC, r2=4'hA -> 4'h8, 4'hE, 4'h3, 4'h5; NOP -> res_data 0, RF unchanged.
- Hold res_ready low 5 cycles in WB -> res_valid/res_data stable, instr_ready low, instr_valid pulses ignored; then accept next.
- rst asserted during EXEC and during WB -> next cycle res_valid=0, ALU outputs 0, all RF reads 0.
- ADD r1=r1+r1 with r1=4'h6 -> 4'hC; subsequent instruction reads r1=4'hC.
